// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi link transmit path.
// Contents:
//   K, G0, G1     constraint length and generator polynomials. Bit 2 of a
//                 generator taps the current input bit; bits 1..0 tap the
//                 encoder state.
//   enc_state_t   framer FSM states.
//   sym_t         2-bit code symbol {g0 bit, g1 bit}.
//   conv_sym()    applies both generators to a {b, s[1], s[0]} window.
package viterbi_pkg;

  localparam int K = 3;
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } enc_state_t;

  typedef logic [1:0] sym_t;

  function automatic sym_t conv_sym(input logic [K-1:0] window);
    conv_sym = {^(window & G0), ^(window & G1)};
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Rate-1/2, K=3 convolutional encoder core.
// The state holds the two previous input bits: s[1] is the newest, s[0] the
// older one. sym is combinational from b and s. The state shifts only when
// en is high.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset; clears the state to 00
//   en   shift b into the state at the next edge
//   b    bit being encoded this cycle
//   sym  code symbol for b given the current state
module conv_enc_core
  import viterbi_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic b,
  output sym_t sym
);

  logic [K-2:0] s;

  assign sym = conv_sym({b, s});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s <= '0;
    end else if (en) begin
      s <= {b, s[1]};
    end
  end

endmodule

// File: rtl/conv_enc_framer.sv
// Framed convolutional encoder. It accepts FRAME_LEN payload bits, then
// appends two zero tail bits so the trellis returns to state 00. It emits
// one registered code symbol per encoded bit and marks the frame with
// sof and eof.
//
// Handshake (both sides): a transfer happens on a rising edge where valid
// and ready are both high. Once valid is raised, it stays high and the data
// stays stable until the transfer.
//
// Ports:
//   clk, rst       clock; asynchronous active-low reset
//   in_valid_i     payload bit offered
//   in_bit_i       payload bit
//   in_ready_o     payload bit is accepted this cycle
//   out_valid_o    symbol valid
//   out_sym_o      code symbol {g0, g1}
//   out_sof_o      first symbol of the frame
//   out_eof_o      second tail symbol (last of the frame)
//   out_ready_i    downstream accepts the symbol
//   dbg_state_o    current framer FSM state, for observation only
module conv_enc_framer
  import viterbi_pkg::*;
#(
  parameter int FRAME_LEN = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid_i,
  input  logic       in_bit_i,
  output logic       in_ready_o,
  output logic       out_valid_o,
  output sym_t       out_sym_o,
  output logic       out_sof_o,
  output logic       out_eof_o,
  input  logic       out_ready_i,
  output enc_state_t dbg_state_o
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  // Count value held in DATA just before the frame's last payload bit is accepted.
  localparam logic [CW-1:0] LAST_PRE = CW'(FRAME_LEN - 1);

  enc_state_t    state, state_n;
  logic [CW-1:0] bit_cnt, bit_cnt_n;
  logic          tail_cnt, tail_cnt_n;
  logic          run;
  logic          advance, accept, en, enc_b;
  sym_t          sym;

  // The output register can take a new symbol when it is empty or when its
  // current symbol leaves on this edge.
  assign advance = !out_valid_o || out_ready_i;

  // run goes high on the first edge after reset is released. It keeps
  // in_ready_o low while reset is asserted without feeding rst into
  // the datapath.
  assign in_ready_o = run && advance && (state != TAIL);
  assign accept     = in_valid_i && in_ready_o;
  assign en         = advance && (accept || (state == TAIL));
  assign enc_b      = (state == TAIL) ? 1'b0 : in_bit_i;

  assign dbg_state_o = state;

  conv_enc_core u_core (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .b   (enc_b),
    .sym (sym)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      tail_cnt <= 1'b0;
      run      <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      tail_cnt <= tail_cnt_n;
      run      <= 1'b1;
    end
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    tail_cnt_n = tail_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          bit_cnt_n = CW'(1);
          if (FRAME_LEN == 1) begin
            state_n    = TAIL;
            tail_cnt_n = 1'b0;
          end else begin
            state_n = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == LAST_PRE) begin
            state_n    = TAIL;
            tail_cnt_n = 1'b0;
          end
        end
      end
      TAIL: begin
        if (advance) begin
          tail_cnt_n = 1'b1;
          if (tail_cnt) begin
            state_n    = IDLE;
            bit_cnt_n  = '0;
            tail_cnt_n = 1'b0;
          end
        end
      end
      default: begin
        state_n    = IDLE;
        bit_cnt_n  = '0;
        tail_cnt_n = 1'b0;
      end
    endcase
  end

  // If a cycle on advance has nothing to encode, the register is emptied
  // and its fields are zeroed. A stalled symbol is simply held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_o <= 1'b0;
      out_sym_o   <= '0;
      out_sof_o   <= 1'b0;
      out_eof_o   <= 1'b0;
    end else if (advance) begin
      out_valid_o <= en;
      out_sym_o   <= en ? sym : '0;
      out_sof_o   <= en && (state == IDLE);
      out_eof_o   <= en && (state == TAIL) && tail_cnt;
    end
  end

endmodule

// File: doc/conv_enc_framer.md
# conv_enc_framer

Framed rate-1/2, K=3 convolutional encoder: the transmit end of the Viterbi link feeding the channel/decoder path. Accepts payload bits over a valid/ready handshake and emits one 2-bit code symbol per accepted bit. After every FRAME_LEN payload bits it appends K-1 zero tail bits so the trellis terminates in state 00 at each frame boundary. Symbols leave through a registered valid/ready output with sof/eof markers.

## Interface
- FRAME_LEN, 256, payload bits per frame (≥1)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid_i  in  1  payload bit valid
- in_bit_i  in  1  payload bit
- in_ready_o  out  1  block accepts in_bit_i this cycle
- out_valid_o  out  1  symbol valid
- out_sym_o  out  2  code symbol {g0 bit, g1 bit}
- out_sof_o  out  1  first symbol of frame
- out_eof_o  out  1  last (second tail) symbol of frame
- out_ready_i  in  1  downstream accepts symbol

## Operation
- Encoder state s[1:0]: s[1] = previous bit, s[0] = bit before that. On each encoded bit b: out_sym_o[1] = b^s[1]^s[0] (g0 = 111), out_sym_o[0] = b^s[0] (g1 = 101); then s[1] <= b, s[0] <= s[1].
- advance = !out_valid_o || out_ready_i. The output register and encoder state update only on advance.
- FSM IDLE / DATA / TAIL:
  - IDLE: in_ready_o = advance. On accept: encode, set out_sof_o, bit_cnt <= 1. Go to DATA, or to TAIL if FRAME_LEN == 1.
  - DATA: in_ready_o = advance. On accept: encode, bit_cnt++. When the accepted bit is bit FRAME_LEN, go to TAIL with tail_cnt = 0.
  - TAIL: in_ready_o = 0. On each advance: encode b = 0, tail_cnt++. The second tail symbol sets out_eof_o. Go to IDLE; s is 00 by construction.
- No input accept in a cycle means no symbol is loaded. If advance is true, out_valid_o drops to 0.
- bit_cnt width: $clog2(FRAME_LEN+1). No wrap within a frame; it is cleared on entry to IDLE.
- Reset mid-frame: async clear of all state. The partial frame is discarded and no eof is emitted.

## Timing
- Reset values: in_ready_o 0 while rst low (1 from the first cycle after release if out_valid_o = 0). out_valid_o 0, out_sym_o 00, out_sof_o 0, out_eof_o 0, s 00, FSM IDLE, counters 0.
- Latency: bit accepted at edge N appears on out_sym_o with out_valid_o after edge N (1 cycle).
- Output holds stable while out_valid_o && !out_ready_i. in_ready_o is low during that stall.
- Throughput: 1 symbol/cycle with out_ready_i high. A frame occupies FRAME_LEN+2 output cycles. The next frame's first bit is accepted the cycle after the second tail symbol is loaded (IDLE).
- Simultaneous out accept and new load in the same cycle is legal, with no bubble.

## Structure
- Package viterbi_pkg holds:
  - K = 3
  - G0 = 3'b111, G1 = 3'b101
  - typedef enum {IDLE, DATA, TAIL} enc_state_t
  - typedef logic [1:0] sym_t
- Sub-module conv_enc_core: holds s[1:0] and the generator XORs, with ports clk, rst, en, b, sym. Its state updates on en. The framer FSM drives en = advance && (accept || TAIL).

## Test plan
- Impulse, FRAME_LEN = 3, inputs 1,0,0, out_ready_i = 1 → symbols 11,10,11 then tails 00,00. sof on the first symbol, eof on the last.
- FRAME_LEN = 4, inputs 1,0,1,1 → 11,10,00,01, tail 01,11. Final s = 00; in_ready_o is low for 2 cycles during TAIL.
- Backpressure: hold out_ready_i = 0 for 3 cycles mid-frame → out_sym_o and out_valid_o stable, in_ready_o = 0, no bit lost. The symbol sequence matches the unstalled case.
- Gappy input: in_valid_i toggling 1/0 → out_valid_o pulses only for accepted bits. Frame boundary and eof still fall after exactly FRAME_LEN payload bits.
- Reset mid-DATA after 2 bits → all outputs 0 immediately (async). The next frame starts with sof and encodes from s = 00 (input 1 → 11).
- Back-to-back frames, FRAME_LEN = 256, continuous random input → 258 symbols per frame, no gap between eof and the next sof beyond one IDLE accept. Decoder loopback output equals the input.
